// File: rtl/imm_ctrl.sv
// Decode-stage immediate controller: classifies RV32I immediate formats, packs the
// immediate bits for the extender and buffers results in a 2-entry skid pipeline.
module imm_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ext_op,
  output logic             out_unsigned_op,
  output logic [19:0]      out_imm_field,
  output logic [1:0]       out_shl,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Entry layout: {illegal, ext_op, unsigned_op, shl[1:0], field[19:0]}
  localparam int unsigned PW = 25;

  logic [PW-1:0]    dec;
  logic [PW-1:0]    main_q, main_d, skid_q, skid_d;
  logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, xfer;

  always_comb begin
    dec = '0;
    case (in_inst[6:0])
      OPC_OPIMM:           dec = {1'b0, 1'b0, (in_inst[13:12] == 2'b01), 2'd0, 8'h00, in_inst[31:20]};
      OPC_LOAD, OPC_JALR:  dec = {1'b0, 1'b0, 1'b0, 2'd0, 8'h00, in_inst[31:20]};
      OPC_STORE:           dec = {1'b0, 1'b0, 1'b0, 2'd0, 8'h00, in_inst[31:25], in_inst[11:7]};
      OPC_BRANCH:          dec = {1'b0, 1'b0, 1'b0, 2'd1, 8'h00, in_inst[31], in_inst[7],
                                  in_inst[30:25], in_inst[11:8]};
      OPC_LUI, OPC_AUIPC:  dec = {1'b0, 1'b1, 1'b0, 2'd2, in_inst[31:12]};
      OPC_JAL:             dec = {1'b0, 1'b1, 1'b0, 2'd1, in_inst[31], in_inst[19:12],
                                  in_inst[20], in_inst[30:21]};
      OPC_OP:              dec = '0;
      default:             dec = {1'b1, {(PW-1){1'b0}}};
    endcase
  end

  assign accept = in_valid & in_ready_q;
  assign xfer   = main_v_q & out_ready;

  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    cnt_d    = cnt_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      if (xfer && main_q[PW-1] && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
      if (!main_v_q || xfer) begin
        // Main frees this cycle: skid (older) moves up first, a new accept backfills behind it.
        if (skid_v_q) begin
          main_v_d = 1'b1;
          main_d   = skid_q;
          skid_v_d = accept;
          if (accept) skid_d = dec;
        end else begin
          main_v_d = accept;
          if (accept) main_d = dec;
        end
      end else if (accept) begin
        skid_v_d = 1'b1;
        skid_d   = dec;
      end
    end
    in_ready_d = !skid_v_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = main_v_q;
  assign out_illegal     = main_q[24];
  assign out_ext_op      = main_q[23];
  assign out_unsigned_op = main_q[22];
  assign out_shl         = main_q[21:20];
  assign out_imm_field   = main_q[19:0];
  assign illegal_cnt     = cnt_q;

endmodule

// File: tb/tb_imm_ctrl.sv
// Scoreboard bench for imm_ctrl: directed instructions, expected controls queued on
// accept and compared by a monitor whenever the controller presents an output.
module tb_imm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic        in_ready, out_valid, out_ext_op, out_unsigned_op, out_illegal;
  logic [19:0] out_imm_field;
  logic [1:0]  out_shl;
  logic [7:0]  illegal_cnt;
  logic        in_ready2, out_valid2, out_ext_op2, out_unsigned_op2, out_illegal2;
  logic [19:0] out_imm_field2;
  logic [1:0]  out_shl2;
  logic [1:0]  illegal_cnt2;

  imm_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready), .out_ext_op(out_ext_op),
    .out_unsigned_op(out_unsigned_op), .out_imm_field(out_imm_field), .out_shl(out_shl),
    .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  imm_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_inst(in_inst), .out_valid(out_valid2), .out_ready(out_ready), .out_ext_op(out_ext_op2),
    .out_unsigned_op(out_unsigned_op2), .out_imm_field(out_imm_field2), .out_shl(out_shl2),
    .out_illegal(out_illegal2), .illegal_cnt(illegal_cnt2)
  );

  always #5 clk = ~clk;

  int unsigned  n_checks = 0;
  int unsigned  n_fail = 0;
  int unsigned  n_accepted = 0;
  int unsigned  n_delivered = 0;
  logic [24:0]  cur_exp;
  logic [24:0]  sb_q[$];
  logic [24:0]  act;

  function automatic logic [24:0] mk(logic [19:0] f, logic e, logic u, logic [1:0] s, logic il);
    return {il, e, u, s, f};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  assign act = {out_illegal, out_ext_op, out_unsigned_op, out_shl, out_imm_field};

  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid) begin
        if (out_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_output", {7'd0, act}, 32'hFFFF_FFFF);
          end else begin
            chk("out_data", {7'd0, act}, {7'd0, sb_q.pop_front()});
            n_delivered++;
          end
        end else if (sb_q.size() != 0) begin
          chk("hold_stable", {7'd0, act}, {7'd0, sb_q[0]});
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(cur_exp);
        n_accepted++;
      end
    end
  end

  task automatic cyc(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_accept();
    bit got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = in_ready && rst_n && !flush;
      @(posedge clk);
      #1;
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [31:0] inst, input logic [24:0] e);
    in_inst  = inst;
    cur_exp  = e;
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  localparam logic [31:0] I_ADDI = 32'hFFF00093;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_SLLI = 32'h00309093;
  localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
  localparam logic [31:0] I_JAL  = 32'hFF9FF06F;
  localparam logic [31:0] I_SW   = 32'h00112623;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ILL  = 32'h00000000;

  logic [24:0] e_addi, e_lui, e_slli, e_beq, e_jal, e_sw, e_add, e_ill;
  int unsigned acc0;

  initial begin
    e_addi = mk(20'h00FFF, 1'b0, 1'b0, 2'd0, 1'b0);
    e_lui  = mk(20'h12345, 1'b1, 1'b0, 2'd2, 1'b0);
    e_slli = mk(20'h00003, 1'b0, 1'b1, 2'd0, 1'b0);
    e_beq  = mk(20'h00FFE, 1'b0, 1'b0, 2'd1, 1'b0);
    e_jal  = mk(20'hFFFFC, 1'b1, 1'b0, 2'd1, 1'b0);
    e_sw   = mk(20'h0000C, 1'b0, 1'b0, 2'd0, 1'b0);
    e_add  = mk(20'h00000, 1'b0, 1'b0, 2'd0, 1'b0);
    e_ill  = mk(20'h00000, 1'b0, 1'b0, 2'd0, 1'b1);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = '0; cur_exp = '0;
    cyc(3);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_data", {7'd0, act}, 32'd0);
    chk("rst_cnt", {24'd0, illegal_cnt}, 32'd0);
    #2 rst_n = 1'b1;
    cyc(1);
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Single ADDI: visible the cycle after accept
    send(I_ADDI, e_addi);
    idle();
    chk("addi_latency_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_latency_data", {7'd0, act}, {7'd0, e_addi});
    cyc(2);

    // Back-to-back stream at full throughput
    send(I_LUI, e_lui);
    send(I_SLLI, e_slli);
    send(I_BEQ, e_beq);
    send(I_JAL, e_jal);
    send(I_SW, e_sw);
    send(I_ADD, e_add);
    idle();
    cyc(3);

    // Backpressure: two accepted, third stalls until the consumer drains
    out_ready = 1'b0;
    acc0 = n_accepted;
    send(I_SW, e_sw);
    send(I_LUI, e_lui);
    chk("bp_in_ready_drop", {31'd0, in_ready}, 32'd0);
    in_inst = I_ADDI; cur_exp = e_addi; in_valid = 1'b1;
    cyc(3);
    chk("bp_in_ready_held", {31'd0, in_ready}, 32'd0);
    chk("bp_accepted_two", n_accepted - acc0, 32'd2);
    chk("bp_head_field", {12'd0, out_imm_field}, 32'h0000C);
    out_ready = 1'b1;
    wait_accept();
    idle();
    cyc(4);
    chk("bp_accepted_three", n_accepted - acc0, 32'd3);

    // Illegal counting and saturation of the narrow instance
    send(I_ILL, e_ill);
    send(I_ILL, e_ill);
    send(I_ILL, e_ill);
    idle();
    cyc(3);
    chk("ill_cnt_3", {24'd0, illegal_cnt}, 32'd3);
    chk("ill_cnt2_3", {30'd0, illegal_cnt2}, 32'd3);
    send(I_ILL, e_ill);
    send(I_ILL, e_ill);
    idle();
    cyc(3);
    chk("ill_cnt_5", {24'd0, illegal_cnt}, 32'd5);
    chk("ill_cnt2_sat", {30'd0, illegal_cnt2}, 32'd3);

    // Flush with both entries full and an instruction presented
    out_ready = 1'b0;
    send(I_ILL, e_ill);
    send(I_LUI, e_lui);
    in_inst = I_JAL; cur_exp = e_jal; in_valid = 1'b1; flush = 1'b1;
    cyc(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_full_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_full_in_ready", {31'd0, in_ready}, 32'd1);

    // Flush concurrent with an accept: the accepted word is dropped
    send(I_BEQ, e_beq);
    in_inst = I_SLLI; cur_exp = e_slli; in_valid = 1'b1; flush = 1'b1;
    cyc(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_accept_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    cyc(5);
    chk("flush_no_count", {24'd0, illegal_cnt}, 32'd5);

    // Asynchronous reset in the middle of a held stream
    out_ready = 1'b0;
    send(I_LUI, e_lui);
    send(I_JAL, e_jal);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_data", {7'd0, act}, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("async_rst_cnt", {24'd0, illegal_cnt}, 32'd0);
    cyc(2);
    #2 rst_n = 1'b1;
    cyc(1);
    chk("rerst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    send(I_ADDI, e_addi);
    idle();
    cyc(4);

    chk("sb_drained", sb_q.size(), 32'd0);
    chk("total_delivered", n_delivered, 32'd16);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imm_ctrl.md
Name: imm_ctrl

Overview:
- Decode-stage controller that sequences the immediate extender.
- Accepts 32-bit RV32I instructions on a valid/ready interface and classifies the immediate format (I/I-unsigned/S/B/U/J).
- Packs the scattered immediate bits into the extender's 20-bit field and drives the extender's ext_op/unsigned_op controls plus a post-extension shift code.
- Buffers results in a 2-entry skid pipeline so execute-stage backpressure never drops an instruction.

Parameters:
- CNT_W, 8: width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush (branch redirect)
- in_valid  in  1  instruction valid
- in_ready  out  1  controller can accept an instruction
- in_inst  in  32  instruction word
- out_valid  out  1  decoded immediate controls valid
- out_ready  in  1  downstream accepts
- out_ext_op  out  1  1 = sign-extend from bit 19; 0 = 12-bit mode
- out_unsigned_op  out  1  in 12-bit mode: 1 = zero-extend, 0 = sign-extend from bit 11
- out_imm_field  out  20  packed immediate for the extender
- out_shl  out  2  shift after extension: 0 = none, 1 = <<1, 2 = <<12, 3 unused
- out_illegal  out  1  opcode not recognised
- illegal_cnt  out  CNT_W  saturating count of illegal instructions delivered

Behaviour:
- Reset (async, rst_n=0):
  - both skid entries invalid; out_valid=0; all out_* data = 0; illegal_cnt=0.
  - in_ready=0 while rst_n=0; it becomes 1 on the first clock after release.
- Decode (combinational on in_inst, registered on accept); opcode = inst[6:0]:
  - 0010011 OP-IMM: field={8'h00,inst[31:20]}, ext_op=0, shl=0. unsigned_op=1 when funct3 (inst[14:12]) is 001 or 101 (shifts); otherwise 0.
  - 0000011 LOAD, 1100111 JALR: field={8'h00,inst[31:20]}, ext_op=0, unsigned_op=0, shl=0.
  - 0100011 STORE: field={8'h00,inst[31:25],inst[11:7]}, ext_op=0, unsigned_op=0, shl=0.
  - 1100011 BRANCH: field={8'h00,inst[31],inst[7],inst[30:25],inst[11:8]}, ext_op=0, unsigned_op=0, shl=1.
  - 0110111 LUI, 0010111 AUIPC: field=inst[31:12], ext_op=1, unsigned_op=0, shl=2.
  - 1101111 JAL: field={inst[31],inst[19:12],inst[20],inst[30:21]}, ext_op=1, unsigned_op=0, shl=1.
  - 0110011 OP (R-type): all-zero controls, illegal=0.
  - any other opcode: all-zero controls, illegal=1.
- Pipeline: a main register (drives out_*) plus one skid register.
  - in_ready = skid entry empty (registered, not dependent on out_ready combinationally).
  - Accept occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Latency: accepted instruction appears on out_* the next cycle if the main register is empty or is transferring that cycle.
  - If main is held (out_valid & !out_ready) and an accept occurs, the entry goes to skid and in_ready drops next cycle.
  - When main transfers, skid (if valid) moves into main and the skid frees.
  - Accept and transfer in the same cycle with skid empty: new entry loads main directly, no bubble; sustained throughput is 1 per cycle.
  - FIFO order is always preserved; out_* are stable while out_valid & !out_ready.
- Flush: on the next edge both entries are invalidated and out_valid=0. An accept in the flush cycle is discarded. flush has priority over all other events. illegal_cnt is not cleared.
- illegal_cnt: increments on an output transfer with out_illegal=1. It saturates at all-ones with no wrap. Flushed illegal entries are not counted.
- Reset asserted mid-operation: immediate return to the reset state regardless of pending entries.

Test Plan:
- ADDI 0xFFF00093, out_ready=1 -> next cycle out_valid=1, field=20'h00FFF, ext_op=0, unsigned_op=0, shl=0, illegal=0.
- LUI 0x123452B7 -> field=20'h12345, ext_op=1, shl=2. SLLI 0x00309093 -> field=20'h00003, unsigned_op=1, shl=0.
- BEQ 0xFE000EE3 -> field=20'h00FFE, ext_op=0, unsigned_op=0, shl=1 (extender+shift yields -4). JAL 0xFF9FF06F -> field=20'hFFFFC, ext_op=1, shl=1 (-8).
- Backpressure: out_ready=0, present 3 back-to-back instructions -> 2 accepted, in_ready=0 from the cycle after the 2nd accept. Then raise out_ready -> both delivered in order, 3rd accepted with no loss or duplication.
- Illegal 0x00000000 delivered 3 times -> out_illegal=1 each time, illegal_cnt=3. With CNT_W=2, 5 illegals -> illegal_cnt saturates at 3.
- Flush with both entries full and a concurrent in_valid -> next cycle out_valid=0, in_ready=1, no flushed instruction ever appears. Async rst_n pulse mid-stream -> all outputs 0 immediately.
